// File: rtl/axi4lite_sram_responder.sv
// axi4lite_sram_responder
//   AXI4-Lite subordinate backed by a word-addressed SRAM, with a detector that
//   pulses whenever a write lands on the TOHOST word so a harness can end a run.
//
// Ports
//   aclk, aresetn             clock, asynchronous active-low reset
//   aw*/w*/b*                 write address / data / response channels
//   ar*/r*                    read address / data channels
//   awprot/awcache/arprot/arcache   accepted and ignored
//   tohost_valid              one-cycle pulse after a TOHOST commit with wstrb != 0
//   tohost_data               merged TOHOST word from the most recent such commit
module axi4lite_sram_responder #(
    parameter int unsigned              ADDR_WIDTH  = 32,
    parameter int unsigned              DEPTH_WORDS = 16384,
    parameter logic [ADDR_WIDTH-1:0]    TOHOST_ADDR = 'h6000
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [2:0]            awprot,
    input  logic [3:0]            awcache,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    output logic                  bvalid,
    input  logic                  bready,
    output logic [1:0]            bresp,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [2:0]            arprot,
    input  logic [3:0]            arcache,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [1:0]            rresp,
    output logic [31:0]           rdata,
    output logic                  tohost_valid,
    output logic [31:0]           tohost_data
);

    localparam int unsigned           IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH:0]   MEM_BYTES  = (ADDR_WIDTH+1)'(4 * DEPTH_WORDS);
    localparam logic [IDX_W-1:0]      TOHOST_IDX = TOHOST_ADDR[IDX_W+1:2];
    localparam logic [1:0]            RESP_OKAY   = 2'b00;
    localparam logic [1:0]            RESP_SLVERR = 2'b10;

    logic [31:0]           mem [DEPTH_WORDS];

    logic                  aw_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic                  w_held;
    logic [31:0]           w_data_q;
    logic [3:0]            w_strb_q;

    logic                  commit;
    logic                  aw_in_range;
    logic [IDX_W-1:0]      aw_idx;
    logic                  ar_hs;
    logic                  ar_in_range;
    logic [IDX_W-1:0]      ar_idx;
    logic [31:0]           merged;
    logic                  tohost_hit;

    logic                  unused_sideband;
    assign unused_sideband = ^{awprot, awcache, arprot, arcache};

    assign awready = !aw_held;
    assign wready  = !w_held;
    assign arready = !rvalid;

    // A held pair commits only once the previous response has left or is leaving.
    assign commit      = aw_held && w_held && (!bvalid || bready);
    assign aw_in_range = {1'b0, aw_addr_q} < MEM_BYTES;
    assign aw_idx      = aw_addr_q[IDX_W+1:2];
    assign ar_hs       = arvalid && arready;
    assign ar_in_range = {1'b0, araddr} < MEM_BYTES;
    assign ar_idx      = araddr[IDX_W+1:2];
    // Range check guarantees the upper address bits are zero, so the index compare is exact.
    assign tohost_hit  = commit && aw_in_range && (aw_idx == TOHOST_IDX) && (|w_strb_q);

    always_comb begin
        merged = mem[aw_idx];
        for (int i = 0; i < 4; i++) begin
            if (w_strb_q[i]) merged[8*i +: 8] = w_data_q[8*i +: 8];
        end
    end

    // SRAM has no reset; commit is forced low while aresetn is low because the
    // holding flags are cleared asynchronously.
    always_ff @(posedge aclk) begin
        if (commit && aw_in_range) mem[aw_idx] <= merged;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_held      <= 1'b0;
            aw_addr_q    <= '0;
            w_held       <= 1'b0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            bvalid       <= 1'b0;
            bresp        <= RESP_OKAY;
            rvalid       <= 1'b0;
            rresp        <= RESP_OKAY;
            rdata        <= '0;
            tohost_valid <= 1'b0;
            tohost_data  <= '0;
        end else begin
            if (awvalid && awready) begin
                aw_held   <= 1'b1;
                aw_addr_q <= awaddr;
            end else if (commit) begin
                aw_held   <= 1'b0;
            end

            if (wvalid && wready) begin
                w_held   <= 1'b1;
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end else if (commit) begin
                w_held   <= 1'b0;
            end

            if (commit) begin
                bvalid <= 1'b1;
                bresp  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
            end else if (bready) begin
                bvalid <= 1'b0;
            end

            tohost_valid <= tohost_hit;
            if (tohost_hit) tohost_data <= merged;

            // mem read here sees the pre-commit word on a same-edge collision.
            if (ar_hs) begin
                rvalid <= 1'b1;
                rdata  <= ar_in_range ? mem[ar_idx] : 32'h0;
                rresp  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
            end else if (rready) begin
                rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi4lite_sram_responder.sv
module tb_axi4lite_sram_responder;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [2:0]  awprot  = 3'b0;
    logic [3:0]  awcache = 4'b0;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [2:0]  arprot  = 3'b0;
    logic [3:0]  arcache = 4'b0;
    logic        rvalid, rready;
    logic [1:0]  rresp;
    logic [31:0] rdata;
    logic        tohost_valid;
    logic [31:0] tohost_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 aclk = ~aclk;

    axi4lite_sram_responder dut (
        .aclk(aclk), .aresetn(aresetn),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .awprot(awprot), .awcache(awcache),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .arprot(arprot), .arcache(arcache),
        .rvalid(rvalid), .rready(rready), .rresp(rresp), .rdata(rdata),
        .tohost_valid(tohost_valid), .tohost_data(tohost_data)
    );

    // Present AW+W together for one edge, then wait for the commit edge.
    task automatic write_word(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(posedge aclk); #1;
    endtask

    task automatic read_word(input logic [31:0] addr);
        araddr = addr; arvalid = 1'b1;
        @(posedge aclk); #1;
        arvalid = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        n_cmp++; if (awready !== 1'b1) begin n_bad++; $display("FAIL reset_awready got=%0b exp=1", awready); end
        n_cmp++; if (wready !== 1'b1) begin n_bad++; $display("FAIL reset_wready got=%0b exp=1", wready); end
        n_cmp++; if (arready !== 1'b1) begin n_bad++; $display("FAIL reset_arready got=%0b exp=1", arready); end
        n_cmp++; if (bvalid !== 1'b0) begin n_bad++; $display("FAIL reset_bvalid got=%0b exp=0", bvalid); end
        n_cmp++; if (rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid got=%0b exp=0", rvalid); end
        n_cmp++; if (tohost_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tohost_valid got=%0b exp=0", tohost_valid); end
        n_cmp++; if (tohost_data !== 32'h0) begin n_bad++; $display("FAIL reset_tohost_data got=%h exp=0", tohost_data); end
        n_cmp++; if (rdata !== 32'h0 || rresp !== 2'b00 || bresp !== 2'b00) begin n_bad++; $display("FAIL reset_data got rdata=%h rresp=%0d bresp=%0d exp=0", rdata, rresp, bresp); end
        aresetn = 1'b1;
        @(posedge aclk); #1;
        n_cmp++; if (awready !== 1'b1 || wready !== 1'b1 || arready !== 1'b1) begin n_bad++; $display("FAIL post_reset_ready got aw=%0b w=%0b ar=%0b exp=111", awready, wready, arready); end
    endtask

    task automatic test_basic_write_read();
        awaddr = 32'h4100; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n_cmp++; if (bvalid !== 1'b0) begin n_bad++; $display("FAIL basic_bvalid_early got=%0b exp=0", bvalid); end
        @(posedge aclk); #1;
        n_cmp++; if (bvalid !== 1'b1) begin n_bad++; $display("FAIL basic_bvalid got=%0b exp=1", bvalid); end
        n_cmp++; if (bresp !== 2'b00) begin n_bad++; $display("FAIL basic_bresp got=%0d exp=0", bresp); end
        @(posedge aclk); #1;
        n_cmp++; if (bvalid !== 1'b0) begin n_bad++; $display("FAIL basic_bvalid_clear got=%0b exp=0", bvalid); end
        read_word(32'h4100);
        n_cmp++; if (rvalid !== 1'b1) begin n_bad++; $display("FAIL basic_rvalid got=%0b exp=1", rvalid); end
        n_cmp++; if (rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL basic_rdata got=%h exp=deadbeef", rdata); end
        n_cmp++; if (rresp !== 2'b00) begin n_bad++; $display("FAIL basic_rresp got=%0d exp=0", rresp); end
        n_cmp++; if (arready !== 1'b0) begin n_bad++; $display("FAIL basic_arready_busy got=%0b exp=0", arready); end
        @(posedge aclk); #1;
        n_cmp++; if (rvalid !== 1'b0) begin n_bad++; $display("FAIL basic_rvalid_clear got=%0b exp=0", rvalid); end
    endtask

    task automatic test_w_before_aw();
        wdata = 32'h000000AA; wstrb = 4'b0001; wvalid = 1'b1;
        @(posedge aclk); #1;
        wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (wready !== 1'b0 || bvalid !== 1'b0) begin n_bad++; $display("FAIL wfirst_hold%0d got wready=%0b bvalid=%0b exp=0,0", i, wready, bvalid); end
            if (i < 2) begin @(posedge aclk); #1; end
        end
        awaddr = 32'h4100; awvalid = 1'b1;
        @(posedge aclk); #1;
        awvalid = 1'b0;
        n_cmp++; if (bvalid !== 1'b0) begin n_bad++; $display("FAIL wfirst_bvalid_early got=%0b exp=0", bvalid); end
        @(posedge aclk); #1;
        n_cmp++; if (bvalid !== 1'b1 || bresp !== 2'b00 || wready !== 1'b1) begin n_bad++; $display("FAIL wfirst_commit got bvalid=%0b bresp=%0d wready=%0b exp=1,0,1", bvalid, bresp, wready); end
        read_word(32'h4100);
        n_cmp++; if (rdata !== 32'hDEADBEAA) begin n_bad++; $display("FAIL wfirst_rdata got=%h exp=deadbeaa", rdata); end
        write_word(32'h4100, 32'hFFFFFFFF, 4'b0000);
        n_cmp++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin n_bad++; $display("FAIL strb0_bresp got bvalid=%0b bresp=%0d exp=1,0", bvalid, bresp); end
        read_word(32'h4100);
        n_cmp++; if (rdata !== 32'hDEADBEAA) begin n_bad++; $display("FAIL strb0_rdata got=%h exp=deadbeaa", rdata); end
    endtask

    task automatic test_tohost();
        write_word(32'h6000, 32'h00000001, 4'hF);
        n_cmp++; if (tohost_valid !== 1'b1) begin n_bad++; $display("FAIL tohost_pulse got=%0b exp=1", tohost_valid); end
        n_cmp++; if (tohost_data !== 32'h1) begin n_bad++; $display("FAIL tohost_data got=%h exp=1", tohost_data); end
        @(posedge aclk); #1;
        n_cmp++; if (tohost_valid !== 1'b0) begin n_bad++; $display("FAIL tohost_pulse_width got=%0b exp=0", tohost_valid); end
        n_cmp++; if (tohost_data !== 32'h1) begin n_bad++; $display("FAIL tohost_data_hold got=%h exp=1", tohost_data); end
        write_word(32'h6004, 32'h00000005, 4'hF);
        n_cmp++; if (tohost_valid !== 1'b0 || tohost_data !== 32'h1) begin n_bad++; $display("FAIL tohost_neighbour got valid=%0b data=%h exp=0,1", tohost_valid, tohost_data); end
        write_word(32'h6000, 32'h00000077, 4'b0000);
        n_cmp++; if (tohost_valid !== 1'b0) begin n_bad++; $display("FAIL tohost_strb0 got=%0b exp=0", tohost_valid); end
        write_word(32'h6000, 32'h0000AB00, 4'b0010);
        n_cmp++; if (tohost_valid !== 1'b1 || tohost_data !== 32'h0000AB01) begin n_bad++; $display("FAIL tohost_merge got valid=%0b data=%h exp=1,0000ab01", tohost_valid, tohost_data); end
    endtask

    task automatic test_out_of_range();
        write_word(32'h0000, 32'h12345678, 4'hF);
        read_word(32'h10000);
        n_cmp++; if (rvalid !== 1'b1 || rresp !== 2'b10 || rdata !== 32'h0) begin n_bad++; $display("FAIL oor_read got rvalid=%0b rresp=%0d rdata=%h exp=1,2,0", rvalid, rresp, rdata); end
        @(posedge aclk); #1;
        write_word(32'h10000, 32'hCAFEF00D, 4'hF);
        n_cmp++; if (bvalid !== 1'b1 || bresp !== 2'b10) begin n_bad++; $display("FAIL oor_write got bvalid=%0b bresp=%0d exp=1,2", bvalid, bresp); end
        read_word(32'h0000);
        n_cmp++; if (rdata !== 32'h12345678 || rresp !== 2'b00) begin n_bad++; $display("FAIL oor_word0 got rdata=%h rresp=%0d exp=12345678,0", rdata, rresp); end
        @(posedge aclk); #1;
        write_word(32'hFFFC, 32'h0A0B0C0D, 4'hF);
        n_cmp++; if (bresp !== 2'b00) begin n_bad++; $display("FAIL last_word_bresp got=%0d exp=0", bresp); end
        read_word(32'hFFFC);
        n_cmp++; if (rdata !== 32'h0A0B0C0D || rresp !== 2'b00) begin n_bad++; $display("FAIL last_word_read got rdata=%h rresp=%0d exp=0a0b0c0d,0", rdata, rresp); end
        @(posedge aclk); #1;
    endtask

    task automatic test_collision();
        write_word(32'h0300, 32'hAAAA0000, 4'hF);
        awaddr = 32'h0300; wdata = 32'hBBBB1111; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h0300; arvalid = 1'b1;
        @(posedge aclk); #1;
        arvalid = 1'b0;
        n_cmp++; if (bvalid !== 1'b1 || rvalid !== 1'b1) begin n_bad++; $display("FAIL collide_valids got bvalid=%0b rvalid=%0b exp=1,1", bvalid, rvalid); end
        n_cmp++; if (rdata !== 32'hAAAA0000) begin n_bad++; $display("FAIL collide_old_data got=%h exp=aaaa0000", rdata); end
        @(posedge aclk); #1;
        read_word(32'h0300);
        n_cmp++; if (rdata !== 32'hBBBB1111) begin n_bad++; $display("FAIL collide_new_data got=%h exp=bbbb1111", rdata); end
        @(posedge aclk); #1;
    endtask

    task automatic test_bready_stall();
        bready = 1'b0;
        write_word(32'h10004, 32'h00000099, 4'hF);
        n_cmp++; if (bvalid !== 1'b1 || bresp !== 2'b10) begin n_bad++; $display("FAIL stall_first got bvalid=%0b bresp=%0d exp=1,2", bvalid, bresp); end
        awaddr = 32'h0204; wdata = 32'h22222222; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (bvalid !== 1'b1 || bresp !== 2'b10 || awready !== 1'b0 || wready !== 1'b0) begin n_bad++; $display("FAIL stall_hold%0d got bvalid=%0b bresp=%0d awready=%0b wready=%0b exp=1,2,0,0", i, bvalid, bresp, awready, wready); end
            @(posedge aclk); #1;
        end
        bready = 1'b1;
        @(posedge aclk); #1;
        n_cmp++; if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b1) begin n_bad++; $display("FAIL stall_release got bvalid=%0b bresp=%0d awready=%0b exp=1,0,1", bvalid, bresp, awready); end
        @(posedge aclk); #1;
        n_cmp++; if (bvalid !== 1'b0) begin n_bad++; $display("FAIL stall_drain got=%0b exp=0", bvalid); end
        read_word(32'h0204);
        n_cmp++; if (rdata !== 32'h22222222) begin n_bad++; $display("FAIL stall_data got=%h exp=22222222", rdata); end
        @(posedge aclk); #1;

        bready = 1'b0;
        write_word(32'h0208, 32'h33333333, 4'hF);
        awaddr = 32'h0204; wdata = 32'h44444444; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        #2 aresetn = 1'b0;
        #1;
        n_cmp++; if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin n_bad++; $display("FAIL stall_reset got bvalid=%0b awready=%0b wready=%0b exp=0,1,1", bvalid, awready, wready); end
        @(posedge aclk); #1;
        aresetn = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        n_cmp++; if (bvalid !== 1'b0) begin n_bad++; $display("FAIL reset_no_commit got bvalid=%0b exp=0", bvalid); end
        bready = 1'b1;
        read_word(32'h0204);
        n_cmp++; if (rdata !== 32'h22222222) begin n_bad++; $display("FAIL reset_discard got=%h exp=22222222", rdata); end
        @(posedge aclk); #1;
        read_word(32'h0208);
        n_cmp++; if (rdata !== 32'h33333333) begin n_bad++; $display("FAIL reset_keeps_sram got=%h exp=33333333", rdata); end
        @(posedge aclk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0;
        awvalid = 1'b0; awaddr = '0;
        wvalid  = 1'b0; wdata  = '0; wstrb = '0;
        arvalid = 1'b0; araddr = '0;
        bready  = 1'b1; rready = 1'b1;
        #1;
        test_reset();
        test_basic_write_read();
        test_w_before_aw();
        test_tohost();
        test_out_of_range();
        test_collision();
        test_bready_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
